// File: rtl/info_screen_sequencer.sv
// rtl/info_screen_sequencer.sv - game-phase sequencer for title, level banner, play and game-over overlays
// Owns lives/level/win and paces banner, game-over and blink timing on start-of-frame strobes.
module info_screen_sequencer #(
    parameter int INIT_LIVES      = 3,
    parameter int MAX_LEVEL       = 9,
    parameter int BANNER_FRAMES   = 120,
    parameter int GAMEOVER_FRAMES = 180,
    parameter int BLINK_FRAMES    = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       spaceKey,
    input  logic       playerHit,
    input  logic       levelCleared,
    output logic       titleEnable,
    output logic       pressSpaceEnable,
    output logic       lifeEnable,
    output logic       levelEnable,
    output logic       gameOverEnable,
    output logic       gameRunning,
    output logic [2:0] lives,
    output logic [3:0] level,
    output logic       win
);

    localparam logic [7:0] BANNER_LAST   = 8'(BANNER_FRAMES);
    localparam logic [7:0] GAMEOVER_LAST = 8'(GAMEOVER_FRAMES);
    localparam logic [7:0] BLINK_LAST    = 8'(BLINK_FRAMES);
    localparam logic [2:0] LIVES_START   = 3'(INIT_LIVES);
    localparam logic [3:0] LEVEL_LAST    = 4'(MAX_LEVEL);

    typedef enum logic [1:0] {
        S_TITLE,
        S_BANNER,
        S_PLAY,
        S_GAMEOVER
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       blink_q, blink_d;
    logic       space_q;
    logic [2:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic       win_q, win_d;

    logic       space_press;
    logic [7:0] frame_cnt_inc;

    assign space_press   = spaceKey & ~space_q;
    assign frame_cnt_inc = frame_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_TITLE;
            frame_cnt_q <= 8'd0;
            blink_q     <= 1'b1;
            space_q     <= 1'b0;
            lives_q     <= 3'd0;
            level_q     <= 4'd0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            space_q     <= spaceKey;
            lives_q     <= lives_d;
            level_q     <= level_d;
            win_q       <= win_d;
        end
    end

    // State-changing events take priority over a coincident frame strobe.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        lives_d     = lives_q;
        level_d     = level_q;
        win_d       = win_q;
        case (state_q)
            S_TITLE: begin
                if (space_press) begin
                    lives_d     = LIVES_START;
                    level_d     = 4'd1;
                    win_d       = 1'b0;
                    frame_cnt_d = 8'd0;
                    state_d     = S_BANNER;
                end else if (startOfFrame) begin
                    if (frame_cnt_inc == BLINK_LAST) begin
                        blink_d     = ~blink_q;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_inc;
                    end
                end
            end
            S_BANNER: begin
                if (startOfFrame) begin
                    if (frame_cnt_inc == BANNER_LAST) begin
                        frame_cnt_d = 8'd0;
                        state_d     = S_PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_inc;
                    end
                end
            end
            S_PLAY: begin
                if (playerHit) begin
                    frame_cnt_d = 8'd0;
                    if (lives_q <= 3'd1) begin
                        lives_d = 3'd0;
                        state_d = S_GAMEOVER;
                    end else begin
                        lives_d = lives_q - 3'd1;
                        state_d = S_BANNER;
                    end
                end else if (levelCleared) begin
                    frame_cnt_d = 8'd0;
                    if (level_q >= LEVEL_LAST) begin
                        win_d   = 1'b1;
                        state_d = S_GAMEOVER;
                    end else begin
                        level_d = level_q + 4'd1;
                        state_d = S_BANNER;
                    end
                end
            end
            S_GAMEOVER: begin
                if (startOfFrame) begin
                    if (frame_cnt_inc == GAMEOVER_LAST) begin
                        frame_cnt_d = 8'd0;
                        blink_d     = 1'b1;
                        state_d     = S_TITLE;
                    end else begin
                        frame_cnt_d = frame_cnt_inc;
                    end
                end
            end
            default: state_d = S_TITLE;
        endcase
    end

    always_comb begin
        titleEnable      = 1'b0;
        pressSpaceEnable = 1'b0;
        lifeEnable       = 1'b0;
        levelEnable      = 1'b0;
        gameOverEnable   = 1'b0;
        gameRunning      = 1'b0;
        case (state_q)
            S_TITLE: begin
                titleEnable      = 1'b1;
                pressSpaceEnable = blink_q;
            end
            S_BANNER: begin
                levelEnable = 1'b1;
                lifeEnable  = 1'b1;
            end
            S_PLAY: begin
                levelEnable = 1'b1;
                lifeEnable  = 1'b1;
                gameRunning = 1'b1;
            end
            S_GAMEOVER: begin
                gameOverEnable = 1'b1;
                lifeEnable     = 1'b1;
            end
            default: titleEnable = 1'b1;
        endcase
    end

    assign lives = lives_q;
    assign level = level_q;
    assign win   = win_q;

endmodule

// File: tb/tb_info_screen_sequencer.sv
// tb/tb_info_screen_sequencer.sv - self-checking bench for info_screen_sequencer
module tb_info_screen_sequencer;

    localparam int INIT_LIVES      = 3;
    localparam int MAX_LEVEL       = 9;
    localparam int BANNER_FRAMES   = 120;
    localparam int GAMEOVER_FRAMES = 180;
    localparam int BLINK_FRAMES    = 30;

    localparam int PH_TITLE  = 0;
    localparam int PH_BANNER = 1;
    localparam int PH_PLAY   = 2;
    localparam int PH_OVER   = 3;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       spaceKey = 1'b0;
    logic       playerHit = 1'b0;
    logic       levelCleared = 1'b0;
    logic       titleEnable, pressSpaceEnable, lifeEnable, levelEnable, gameOverEnable, gameRunning;
    logic [2:0] lives;
    logic [3:0] level;
    logic       win;

    info_screen_sequencer #(
        .INIT_LIVES     (INIT_LIVES),
        .MAX_LEVEL      (MAX_LEVEL),
        .BANNER_FRAMES  (BANNER_FRAMES),
        .GAMEOVER_FRAMES(GAMEOVER_FRAMES),
        .BLINK_FRAMES   (BLINK_FRAMES)
    ) u_dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .spaceKey        (spaceKey),
        .playerHit       (playerHit),
        .levelCleared    (levelCleared),
        .titleEnable     (titleEnable),
        .pressSpaceEnable(pressSpaceEnable),
        .lifeEnable      (lifeEnable),
        .levelEnable     (levelEnable),
        .gameOverEnable  (gameOverEnable),
        .gameRunning     (gameRunning),
        .lives           (lives),
        .level           (level),
        .win             (win)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: phase plus frames elapsed in that phase; blink derives from title time.
    int m_phase, m_frames, m_lives, m_level;
    bit m_win, m_space_prev;

    function automatic void model_reset();
        m_phase = PH_TITLE; m_frames = 0; m_lives = 0; m_level = 0;
        m_win = 1'b0; m_space_prev = 1'b0;
    endfunction

    function automatic bit model_blink();
        return ((m_frames / BLINK_FRAMES) % 2) == 0;
    endfunction

    function automatic void model_step(bit sof, bit sp, bit hit, bit clr);
        bit press;
        press = sp && !m_space_prev;
        m_space_prev = sp;
        case (m_phase)
            PH_TITLE: begin
                if (press) begin
                    m_lives = INIT_LIVES; m_level = 1; m_win = 1'b0;
                    m_phase = PH_BANNER; m_frames = 0;
                end else if (sof) m_frames++;
            end
            PH_BANNER: if (sof) begin
                m_frames++;
                if (m_frames == BANNER_FRAMES) begin m_phase = PH_PLAY; m_frames = 0; end
            end
            PH_PLAY: begin
                if (hit) begin
                    m_lives--;
                    m_phase = (m_lives == 0) ? PH_OVER : PH_BANNER;
                    m_frames = 0;
                end else if (clr) begin
                    if (m_level == MAX_LEVEL) begin m_win = 1'b1; m_phase = PH_OVER; end
                    else begin m_level++; m_phase = PH_BANNER; end
                    m_frames = 0;
                end
            end
            default: if (sof) begin
                m_frames++;
                if (m_frames == GAMEOVER_FRAMES) begin m_phase = PH_TITLE; m_frames = 0; end
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".titleEnable"},      8'(titleEnable),      8'(m_phase == PH_TITLE));
        chk({tag, ".pressSpaceEnable"}, 8'(pressSpaceEnable), 8'(m_phase == PH_TITLE && model_blink()));
        chk({tag, ".lifeEnable"},       8'(lifeEnable),       8'(m_phase != PH_TITLE));
        chk({tag, ".levelEnable"},      8'(levelEnable),      8'(m_phase == PH_BANNER || m_phase == PH_PLAY));
        chk({tag, ".gameOverEnable"},   8'(gameOverEnable),   8'(m_phase == PH_OVER));
        chk({tag, ".gameRunning"},      8'(gameRunning),      8'(m_phase == PH_PLAY));
        chk({tag, ".lives"},            8'(lives),            8'(m_lives));
        chk({tag, ".level"},            8'(level),            8'(m_level));
        chk({tag, ".win"},              8'(win),              8'(m_win));
    endtask

    task automatic tick(input bit sof, input bit sp, input bit hit, input bit clr);
        startOfFrame = sof; spaceKey = sp; playerHit = hit; levelCleared = clr;
        @(posedge clk);
        model_step(sof, sp, hit, clr);
        #1;
        check_outputs("cyc");
        startOfFrame = 1'b0; playerHit = 1'b0; levelCleared = 1'b0;
    endtask

    task automatic run_banner();
        for (int i = 0; i < BANNER_FRAMES - 1; i++) tick(1, 0, 0, 0);
        chk("banner_pre_run", 8'(gameRunning), 8'd0);
        tick(1, 0, 0, 0);
        chk("banner_post_run", 8'(gameRunning), 8'd1);
    endtask

    initial begin
        logic sp_r;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk) resetN = 1'b1;

        for (int i = 1; i <= 60; i++) begin
            tick(1, 0, 0, 0);
            tick(0, 0, 0, 0);
            if (i == 29) chk("blink_p29", 8'(pressSpaceEnable), 8'd1);
            if (i == 30) chk("blink_p30", 8'(pressSpaceEnable), 8'd0);
            if (i == 60) chk("blink_p60", 8'(pressSpaceEnable), 8'd1);
        end

        tick(0, 1, 0, 0);
        chk("start_lives", 8'(lives), 8'd3);
        chk("start_level", 8'(level), 8'd1);
        chk("start_levelEn", 8'(levelEnable), 8'd1);
        tick(0, 1, 1, 0);
        chk("banner_hit_lives", 8'(lives), 8'd3);
        run_banner();

        tick(0, 0, 1, 0);
        chk("hit_lives2", 8'(lives), 8'd2);
        run_banner();
        tick(0, 0, 0, 1);
        run_banner();
        tick(0, 0, 0, 1);
        chk("clr_level3", 8'(level), 8'd3);
        run_banner();

        tick(0, 0, 1, 1);
        chk("both_lives", 8'(lives), 8'd1);
        chk("both_level", 8'(level), 8'd3);
        chk("both_banner", 8'(levelEnable & ~gameRunning), 8'd1);
        run_banner();

        for (int lv = 3; lv < MAX_LEVEL; lv++) begin
            tick(0, 0, 0, 1);
            chk("clr_level_next", 8'(level), 8'(lv + 1));
            run_banner();
        end

        tick(0, 1, 0, 1);
        chk("win_flag", 8'(win), 8'd1);
        chk("win_over", 8'(gameOverEnable), 8'd1);
        chk("win_level", 8'(level), 8'd9);
        for (int i = 0; i < GAMEOVER_FRAMES; i++) tick(1, 1, 0, 0);
        chk("over_title", 8'(titleEnable), 8'd1);
        chk("over_blink", 8'(pressSpaceEnable), 8'd1);
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
        chk("held_space_title", 8'(titleEnable), 8'd1);
        chk("held_space_win", 8'(win), 8'd1);

        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        chk("restart_win", 8'(win), 8'd0);
        chk("restart_lives", 8'(lives), 8'd3);
        run_banner();
        for (int k = 1; k <= 3; k++) begin
            tick(0, 0, 1, 0);
            chk("hit_seq_lives", 8'(lives), 8'(3 - k));
            if (k < 3) run_banner();
        end
        chk("lose_over", 8'(gameOverEnable), 8'd1);
        chk("lose_win", 8'(win), 8'd0);
        for (int i = 0; i < GAMEOVER_FRAMES; i++) tick(1, 0, 0, 0);
        chk("lose_title", 8'(titleEnable), 8'd1);
        chk("lose_blink", 8'(pressSpaceEnable), 8'd1);

        sp_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) sp_r = ~sp_r;
            tick(1'($urandom_range(0, 1)), sp_r, $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0);
        end

        for (int i = 0; i < 2000 && m_phase != PH_PLAY; i++) tick(1, i[0], 0, 0);
        chk("reach_play", 8'(gameRunning), 8'd1);
        spaceKey = 1'b0;
        #2 resetN = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        check_outputs("held_reset");
        @(negedge clk) resetN = 1'b1;
        tick(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/info_screen_sequencer.md
# info_screen_sequencer

Game-phase controller that decides which info overlay the display multiplexer shows and when. It sequences title, level banner, play and game-over screens, and owns the lives and level counters. It drives the per-overlay enables that gate the title, press-space, life, level and game-over drawers. It is paced by a one-cycle start-of-frame strobe.

## Interface
Parameters:
- INIT_LIVES, 3: lives loaded at game start (1..7)
- MAX_LEVEL, 9: last level; clearing it ends the game with win=1 (1..15)
- BANNER_FRAMES, 120: frames the level banner is held (1..255)
- GAMEOVER_FRAMES, 180: frames the game-over screen is held (1..255)
- BLINK_FRAMES, 30: half-period of the press-space blink, in frames (1..255)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse, once per video frame
- spaceKey  in  1  level-sensitive space key, already synchronised
- playerHit  in  1  one-cycle pulse, player lost a life
- levelCleared  in  1  one-cycle pulse, all balls of the level destroyed
- titleEnable  out  1  draw title overlay
- pressSpaceEnable  out  1  draw press-space overlay (blinking)
- lifeEnable  out  1  draw lives overlay
- levelEnable  out  1  draw level overlay
- gameOverEnable  out  1  draw game-over overlay
- gameRunning  out  1  gameplay objects move and collide
- lives  out  3  remaining lives
- level  out  4  current level, 1-based
- win  out  1  last game ended by clearing MAX_LEVEL

## Operation
- One clock, clk. resetN is asynchronous and active-low.
- States: S_TITLE, S_BANNER, S_PLAY, S_GAMEOVER. Reset state S_TITLE.
- Internal registers:
  - frameCnt, 8 bits.
  - blink, 1 bit.
  - spaceD, 1 bit. spacePress = spaceKey & ~spaceD (rising edge).
- S_TITLE:
  - titleEnable=1, pressSpaceEnable=blink.
  - Every BLINK_FRAMES startOfFrame pulses, blink toggles.
  - On spacePress: lives<=INIT_LIVES, level<=1, win<=0, frameCnt<=0 -> S_BANNER.
- S_BANNER:
  - levelEnable=1, lifeEnable=1.
  - frameCnt increments on each startOfFrame.
  - On the startOfFrame that brings the count to BANNER_FRAMES -> S_PLAY.
- S_PLAY:
  - levelEnable=1, lifeEnable=1, gameRunning=1.
  - playerHit: if lives==1 then lives<=0 -> S_GAMEOVER; else lives<=lives-1 -> S_BANNER (frameCnt<=0).
  - levelCleared: if level==MAX_LEVEL then win<=1 -> S_GAMEOVER; else level<=level+1 -> S_BANNER (frameCnt<=0).
  - playerHit and levelCleared in the same cycle: playerHit wins; levelCleared is dropped.
- S_GAMEOVER:
  - gameOverEnable=1, lifeEnable=1.
  - Counts GAMEOVER_FRAMES startOfFrame pulses, then -> S_TITLE with blink<=1 and frameCnt<=0.
  - lives, level and win hold their values until the next game start.
- Event filtering:
  - playerHit and levelCleared are ignored outside S_PLAY.
  - spacePress is ignored outside S_TITLE. A space key held through S_GAMEOVER does not restart the game; a new rising edge is required.
- Every entry to S_BANNER or S_GAMEOVER clears frameCnt. frameCnt never wraps, because the compare fires first.
- lives never decrements below 0. level never exceeds MAX_LEVEL.
- All enables not listed for a state are 0.

## Timing
- Reset values:
  - Outputs: titleEnable=1, pressSpaceEnable=1, all other enables and gameRunning=0, lives=0, level=0, win=0.
  - Internal: frameCnt=0, blink=1, spaceD=0.
- The block is Moore. Outputs decode only state, blink, lives, level and win; there is no combinational input-to-output path.
- An event sampled at edge N changes state and counters at edge N. Enables reflect the new state in cycle N+1.
- Banner duration is exactly BANNER_FRAMES startOfFrame pulses, counted from the first pulse after entry.
- startOfFrame coinciding with a state-changing event: the event is taken and the pulse is not counted.
- Reset asserted mid-game returns to S_TITLE with reset values immediately (asynchronously); no event is remembered.

## Test plan
- Reset, then 60 startOfFrame pulses in S_TITLE: titleEnable=1 throughout; pressSpaceEnable starts at 1 and toggles after pulses 30 and 60.
- spaceKey rising edge in S_TITLE: lives=3, level=1, levelEnable=lifeEnable=1; gameRunning rises exactly after the 120th startOfFrame.
- In S_PLAY with lives=3, three playerHit pulses separated by banners: lives goes 2, 1, 0; the third hit enters S_GAMEOVER with win=0. After 180 frames titleEnable=1 and pressSpaceEnable=1.
- levelCleared with level=9 in S_PLAY: win=1, gameOverEnable=1, level stays 9. levelCleared with level=4: level=5 and S_BANNER.
- playerHit and levelCleared in the same cycle with lives=2 and level=3: lives=1, level=3, S_BANNER.
- playerHit during S_BANNER, spaceKey held high across S_GAMEOVER into S_TITLE, and resetN pulsed low mid-S_PLAY: the first two cause no state change; reset returns all outputs to their reset values.
